// File: rtl/display_scheduler.sv
// Three-source display arbiter with round-robin dwell, urgent pre-emption
// on source 0, and a free-running 4-digit multiplexed scan.
module display_scheduler #(
    parameter int DWELL_TICKS = 50000000,
    parameter int SCAN_DIV    = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic        urgent,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    input  logic [3:0]  dot0,
    input  logic [3:0]  dot1,
    input  logic [3:0]  dot2,
    output logic [2:0]  grant,
    output logic        grant_change,
    output logic [15:0] disp_value,
    output logic [3:0]  disp_dot,
    output logic [1:0]  digit_sel,
    output logic [3:0]  digit_en,
    output logic [3:0]  digit_nibble,
    output logic        digit_dp
);

    localparam int DW = $clog2(DWELL_TICKS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
    localparam logic [PW-1:0] SCAN_LAST  = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        PREEMPT
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    owner, owner_nx;
    logic [1:0]    rr, rr_nx;
    logic [1:0]    saved, saved_nx;
    logic          saved_valid, saved_valid_nx;
    logic [DW-1:0] dwell, dwell_nx;
    logic [2:0]    grant_nx;
    logic [PW-1:0] presc;
    logic          hot;
    logic          release_now;
    logic [2:0]    pick_rr;
    logic [2:0]    pick_oth;
    logic [15:0]   sel_value;
    logic [3:0]    sel_dot;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Returns {found, index}: first set bit of m scanning upward from start.
    function automatic logic [2:0] pick(input logic [2:0] m,
                                        input logic [1:0] start);
        logic [3:0] mm;
        logic [1:0] c;
        logic [2:0] r;
        mm = {1'b0, m};
        c  = start;
        r  = 3'b000;
        for (int k = 0; k < 3; k++) begin
            if (!r[2] && mm[c]) begin
                r = {1'b1, c};
            end
            c = inc3(c);
        end
        return r;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    assign hot         = req[0] & urgent;
    assign pick_rr     = pick(req, rr);
    assign pick_oth    = pick(req & ~grant, inc3(owner));
    assign release_now = (dwell == DWELL_LAST) || ((req & grant) == 3'b000);

    always_comb begin
        state_nx       = state;
        owner_nx       = owner;
        rr_nx          = rr;
        saved_nx       = saved;
        saved_valid_nx = saved_valid;
        dwell_nx       = dwell;
        grant_nx       = grant;
        unique case (state)
            IDLE: begin
                if (hot) begin
                    state_nx = PREEMPT;
                    owner_nx = 2'd0;
                    grant_nx = 3'b001;
                    dwell_nx = '0;
                end else if (pick_rr[2]) begin
                    state_nx = SHOW;
                    owner_nx = pick_rr[1:0];
                    grant_nx = onehot(pick_rr[1:0]);
                    dwell_nx = '0;
                end
            end
            SHOW: begin
                if (hot) begin
                    state_nx       = PREEMPT;
                    owner_nx       = 2'd0;
                    grant_nx       = 3'b001;
                    saved_nx       = owner;
                    saved_valid_nx = 1'b1;
                end else if (release_now) begin
                    dwell_nx = '0;
                    if (pick_oth[2]) begin
                        owner_nx = pick_oth[1:0];
                        grant_nx = onehot(pick_oth[1:0]);
                        rr_nx    = inc3(pick_oth[1:0]);
                    end else if ((req & grant) != 3'b000) begin
                        rr_nx = inc3(owner);
                    end else begin
                        state_nx = IDLE;
                        grant_nx = 3'b000;
                    end
                end else begin
                    dwell_nx = dwell + 1'b1;
                end
            end
            PREEMPT: begin
                if (!hot) begin
                    saved_valid_nx = 1'b0;
                    dwell_nx       = '0;
                    if (saved_valid && ((req & onehot(saved)) != 3'b000)) begin
                        state_nx = SHOW;
                        owner_nx = saved;
                        grant_nx = onehot(saved);
                    end else if (pick_rr[2]) begin
                        state_nx = SHOW;
                        owner_nx = pick_rr[1:0];
                        grant_nx = onehot(pick_rr[1:0]);
                    end else begin
                        state_nx = IDLE;
                        grant_nx = 3'b000;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = 3'b000;
            end
        endcase
    end

    // Display copy follows the grant being installed on this same edge.
    always_comb begin
        sel_value = '0;
        sel_dot   = '0;
        unique case (1'b1)
            grant_nx[0]: begin
                sel_value = data0;
                sel_dot   = dot0;
            end
            grant_nx[1]: begin
                sel_value = data1;
                sel_dot   = dot1;
            end
            grant_nx[2]: begin
                sel_value = data2;
                sel_dot   = dot2;
            end
            default: begin
                sel_value = '0;
                sel_dot   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= 2'd0;
            rr           <= 2'd0;
            saved        <= 2'd0;
            saved_valid  <= 1'b0;
            dwell        <= '0;
            grant        <= 3'b000;
            grant_change <= 1'b0;
            disp_value   <= '0;
            disp_dot     <= '0;
        end else begin
            state        <= state_nx;
            owner        <= owner_nx;
            rr           <= rr_nx;
            saved        <= saved_nx;
            saved_valid  <= saved_valid_nx;
            dwell        <= dwell_nx;
            grant        <= grant_nx;
            grant_change <= (grant_nx != grant);
            if (grant_nx != 3'b000) begin
                disp_value <= sel_value;
                disp_dot   <= sel_dot;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            digit_sel <= 2'd0;
        end else if (presc == SCAN_LAST) begin
            presc     <= '0;
            digit_sel <= digit_sel + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign digit_en     = 4'b0001 << digit_sel;
    assign digit_nibble = disp_value[{digit_sel, 2'b00} +: 4];
    assign digit_dp     = disp_dot[digit_sel];

endmodule

// File: tb/tb_display_scheduler.sv
// Randomised and directed checks of display_scheduler against a
// cycle-level behavioural model (DWELL_TICKS=4, SCAN_DIV=2).
module tb_display_scheduler;

    localparam int DT = 4;
    localparam int SD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = '0;
    logic        urgent = 1'b0;
    logic [15:0] data [3];
    logic [3:0]  dot [3];
    logic [2:0]  grant;
    logic        grant_change;
    logic [15:0] disp_value;
    logic [3:0]  disp_dot;
    logic [1:0]  digit_sel;
    logic [3:0]  digit_en;
    logic [3:0]  digit_nibble;
    logic        digit_dp;
    logic [34:0] dut_vec;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: owner -1 = nobody, saved -1 = nothing pre-empted
    int          m_owner, m_rr, m_dwell, m_saved, m_presc, m_dsel;
    bit          m_pre, m_gc;
    logic [15:0] m_dv;
    logic [3:0]  m_dd;

    display_scheduler #(.DWELL_TICKS(DT), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .req(req), .urgent(urgent),
        .data0(data[0]), .data1(data[1]), .data2(data[2]),
        .dot0(dot[0]), .dot1(dot[1]), .dot2(dot[2]),
        .grant(grant), .grant_change(grant_change),
        .disp_value(disp_value), .disp_dot(disp_dot),
        .digit_sel(digit_sel), .digit_en(digit_en),
        .digit_nibble(digit_nibble), .digit_dp(digit_dp)
    );

    always #5 clk = ~clk;

    assign dut_vec = {grant, grant_change, disp_value, disp_dot, digit_sel,
                      digit_en, digit_nibble, digit_dp};

    function automatic logic [2:0] g_of(input int o);
        return (o < 0) ? 3'b000 : 3'(1 << o);
    endfunction

    function automatic int first_from(input int start);
        for (int k = 0; k < 3; k++) begin
            if (req[(start + k) % 3]) return (start + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [34:0] exp_vec();
        return {g_of(m_owner), m_gc, m_dv, m_dd, 2'(m_dsel),
                4'(1 << m_dsel), 4'(m_dv >> (4 * m_dsel)), m_dd[m_dsel]};
    endfunction

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_dwell = 0; m_saved = -1;
        m_presc = 0; m_dsel = 0; m_pre = 0; m_gc = 0;
        m_dv = '0; m_dd = '0;
    endtask

    task automatic model_step();
        bit hot;
        int old;
        int n;
        hot = req[0] && urgent;
        old = m_owner;
        if (m_pre) begin
            if (!hot) begin
                m_pre = 0;
                if (m_saved >= 0 && req[m_saved]) m_owner = m_saved;
                else m_owner = first_from(m_rr);
                m_saved = -1;
                m_dwell = 0;
            end
        end else if (m_owner < 0) begin
            if (hot) begin
                m_pre = 1;
                m_owner = 0;
            end else begin
                m_owner = first_from(m_rr);
            end
            m_dwell = 0;
        end else if (hot) begin
            m_saved = m_owner;
            m_owner = 0;
            m_pre = 1;
        end else if (m_dwell == DT - 1 || !req[m_owner]) begin
            n = -1;
            for (int k = 1; k < 3; k++) begin
                if (n < 0 && req[(m_owner + k) % 3]) n = (m_owner + k) % 3;
            end
            if (n < 0 && req[m_owner]) n = m_owner;
            if (n >= 0) m_rr = (n + 1) % 3;
            m_owner = n;
            m_dwell = 0;
        end else begin
            m_dwell++;
        end
        m_gc = (g_of(old) != g_of(m_owner));
        if (m_owner >= 0) begin
            m_dv = data[m_owner];
            m_dd = dot[m_owner];
        end
        m_presc++;
        if (m_presc == SD) begin
            m_presc = 0;
            m_dsel = (m_dsel + 1) % 4;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        urgent = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_tests++;
        if (dut_vec !== {3'b000, 1'b0, 16'h0, 4'h0, 2'd0, 4'b0001, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h want all-zero with digit_en=0001", dut_vec);
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        logic [2:0] eg;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            data[s] = 16'($urandom);
            dot[s] = 4'($urandom);
        end
        req = 3'b111;
        for (int i = 0; i < 13; i++) begin
            tick();
            eg = (i < 4) ? 3'b001 : (i < 8) ? 3'b010 : (i < 12) ? 3'b100 : 3'b001;
            n_tests++;
            if (grant !== eg || grant_change !== (i % 4 == 0)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b/%b want %b/%b",
                         i, grant, grant_change, eg, (i % 4 == 0));
            end
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL rr_vec[%0d]: got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_early_release(input bit keep2);
        logic [2:0] eg;
        do_reset();
        data[1] = 16'hBEEF;
        dot[1] = 4'b1010;
        data[2] = 16'h0C0D;
        dot[2] = 4'b0001;
        req = 3'b110;
        tick();
        tick();
        req = keep2 ? 3'b100 : 3'b000;
        tick();
        eg = keep2 ? 3'b100 : 3'b000;
        n_tests++;
        if (grant !== eg) begin
            n_fail++;
            $display("FAIL early_release_grant: got %b want %b", grant, eg);
        end
        n_tests++;
        if (!keep2 && (disp_value !== 16'hBEEF || disp_dot !== 4'b1010)) begin
            n_fail++;
            $display("FAIL early_release_hold: got %h/%b want beef/1010",
                     disp_value, disp_dot);
        end
        n_tests++;
        if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL early_release_vec: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_preempt();
        logic [2:0] eg;
        do_reset();
        req = 3'b100;
        tick();
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            req = (i < 3) ? 3'b101 : 3'b100;
            urgent = (i < 3);
            tick();
            eg = (i < 3) ? 3'b001 : 3'b100;
            n_tests++;
            if (grant !== eg || grant_change !== (i == 0 || i == 3)) begin
                n_fail++;
                $display("FAIL preempt_grant[%0d]: got %b/%b want %b/%b",
                         i, grant, grant_change, eg, (i == 0 || i == 3));
            end
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL preempt_vec[%0d]: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        urgent = 1'b0;
    endtask

    task automatic test_scan();
        int sel_e [9] = '{0, 1, 1, 2, 2, 3, 3, 0, 0};
        do_reset();
        data[0] = 16'h1234;
        dot[0] = 4'b0100;
        req = 3'b001;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_tests++;
            if (digit_sel !== 2'(sel_e[i]) || digit_nibble !== 4'(4 - sel_e[i]) ||
                digit_dp !== (sel_e[i] == 2) || digit_en !== 4'(1 << sel_e[i])) begin
                n_fail++;
                $display("FAIL scan[%0d]: got sel=%0d nib=%h dp=%b en=%b want sel=%0d nib=%0d",
                         i, digit_sel, digit_nibble, digit_dp, digit_en,
                         sel_e[i], 4 - sel_e[i]);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        data[1] = 16'($urandom);
        req = 3'b010;
        for (int i = 0; i < 13; i++) begin
            tick();
            n_tests++;
            if (grant !== 3'b010 || grant_change !== (i == 0)) begin
                n_fail++;
                $display("FAIL single[%0d]: got %b/%b want 010/%b",
                         i, grant, grant_change, (i == 0));
            end
        end
    endtask

    task automatic test_reset_mid_preempt();
        do_reset();
        req = 3'b001;
        urgent = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (dut_vec !== {3'b000, 1'b0, 16'h0, 4'h0, 2'd0, 4'b0001, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got %h want all-zero with digit_en=0001", dut_vec);
        end
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
        urgent = 1'b0;
        req = 3'b110;
        tick();
        n_tests++;
        if (grant !== 3'b010 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_regrant: got %b (%h) want 010 (%h)",
                     grant, dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = 3'($urandom);
            urgent = ($urandom_range(0, 9) == 0) ? 1'b1 : (urgent && $urandom_range(0, 2) != 0);
            for (int s = 0; s < 3; s++) begin
                data[s] = 16'($urandom);
                dot[s] = 4'($urandom);
            end
            tick();
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        urgent = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            data[s] = '0;
            dot[s] = '0;
        end
        model_reset();
        test_reset();
        test_round_robin();
        test_early_release(1'b1);
        test_early_release(1'b0);
        test_preempt();
        test_scan();
        test_single();
        test_reset_mid_preempt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter DWELL_TICKS, default 50000000, clk cycles a granted source keeps the display (>=2).
REQ-002 Parameter SCAN_DIV, default 100000, clk cycles per digit scan step (>=2).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 req  in  3  per-source request for display time (bit n = source n).
REQ-006 urgent  in  1  qualifies req[0] as a pre-empting request.
REQ-007 data0, data1, data2  in  16 each  four packed hex/BCD nibbles per source; [3:0] is the rightmost digit.
REQ-008 dot0, dot1, dot2  in  4 each  per-digit decimal-point enables per source.
REQ-009 grant  out  3  one-hot current owner, or 0 when idle.
REQ-010 grant_change  out  1  one-cycle pulse when grant changes value.
REQ-011 disp_value  out  16  registered copy of the granted source's data.
REQ-012 disp_dot  out  4  registered copy of the granted source's dot mask.
REQ-013 digit_sel  out  2  active scan digit.
REQ-014 digit_en  out  4  one-hot active-high digit enable; equals 1<<digit_sel.
REQ-015 digit_nibble  out  4  disp_value nibble for digit_sel.
REQ-016 digit_dp  out  1  disp_dot[digit_sel].

Function
REQ-017 The arbiter SHALL use the states IDLE, SHOW and PREEMPT, and a round-robin pointer rr (0..2).
REQ-018 In IDLE, when req[0] and urgent are both high, the arbiter SHALL enter PREEMPT with grant=001 on the next edge; otherwise, when any req bit is high, it SHALL grant the first requester found by searching from rr upward (wrapping mod 3) and enter SHOW with dwell=0.
REQ-019 In SHOW, dwell SHALL increment each cycle, and release SHALL occur when dwell==DWELL_TICKS-1 or req[granted]==0.
REQ-020 On release, the next grant SHALL be the first requester after the current owner (mod 3), excluding the owner, applied in the same edge with no idle cycle. rr SHALL be set to the new owner+1.
REQ-021 On release, if only the owner still requests, the arbiter SHALL re-grant it with dwell=0; grant_change SHALL stay low.
REQ-022 On release, if no requests remain, the arbiter SHALL go to IDLE with grant=0; disp_value and disp_dot SHALL hold their last values.
REQ-023 In SHOW, when req[0]&urgent, the arbiter SHALL enter PREEMPT next edge with grant=001, save the preempted index (saved_valid=1) and freeze dwell.
REQ-024 PREEMPT SHALL persist while req[0]&urgent; the dwell timer SHALL NOT be applied.
REQ-025 On exit from PREEMPT, if saved_valid and req[saved] is high, the arbiter SHALL return to SHOW granting saved with dwell=0. Otherwise it SHALL arbitrate as in REQ-018 from rr. saved_valid SHALL clear on exit.
REQ-026 Simultaneous urgent and release in SHOW: preemption SHALL win.
REQ-027 disp_value and disp_dot SHALL track the granted source's inputs with exactly 1-cycle latency, including the grant-change edge.
REQ-028 The scan prescaler SHALL count 0..SCAN_DIV-1. On the terminal count, digit_sel SHALL increment, wrapping 3->0. The scan SHALL run continuously in all states.
REQ-029 digit_nibble, digit_dp and digit_en SHALL be combinational functions of the registered digit_sel, disp_value and disp_dot.

Reset
REQ-030 While reset is high, the following SHALL hold: state=IDLE, grant=0, grant_change=0, disp_value=0, disp_dot=0, rr=0, dwell=0, saved_valid=0, prescaler=0, digit_sel=0, digit_en=0001, digit_nibble=0, digit_dp=0.
REQ-031 Reset asserted mid-SHOW or mid-PREEMPT SHALL abort it with no residual state. The first grant after reset SHALL follow REQ-018 with rr=0.

Verification (DWELL_TICKS=4, SCAN_DIV=2)
REQ-032 Round-robin: req=111 held -> grant 001 for 4 cycles, then 010 for 4, then 100 for 4, then 001; grant_change pulses at each switch.
REQ-033 Early release: grant=010, drop req[1] at dwell=1 -> next edge grant=100 if req[2], else IDLE with grant=000 and disp_value held.
REQ-034 Preempt: grant=100 at dwell=2, raise req[0]&urgent for 3 cycles -> grant=001 for 3 cycles, then grant=100 with dwell restarted for a full 4 cycles.
REQ-035 Scan: data0=16'h1234, dot0=0100, grant=001 -> digit_sel sequence 0,0,1,1,2,2,3,3,0 with digit_nibble 4,3,2,1; digit_dp=1 only at digit_sel=2.
REQ-036 Single requester: req=010 only -> grant stays 010 across dwell expiries with grant_change never pulsing after the initial grant.
REQ-037 Reset mid-PREEMPT: assert reset -> all outputs at REQ-030 values immediately (asynchronously); after release, req=110 yields grant=010.
